reg_timeout_guard: RTL

- Register-bus watchdog that sits directly downstream of the AXI-to-regbus converter's reg_req_o/reg_rsp_i pair and upstream of the peripheral register demux.
- Forwards each regbus transaction unchanged. If a peripheral holds ready low for too long, the guard aborts the transaction and answers upstream with an error response.
- This keeps the AXI side from hanging on a dead or unclocked peripheral. It also logs the address of the last timed-out access and keeps a count of timeouts.

---
 rtl/reg_timeout_guard.sv | 118 +++++++++++
 1 files changed

// File: rtl/reg_timeout_guard.sv
// Regbus watchdog: forwards requests unchanged and aborts with an error response
// when the downstream peripheral stalls ready for TimeoutCycles cycles.
package reg_timeout_guard_pkg;
   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } rsp_t;
endpackage

// state  | meaning
// ACTIVE | transparent pass-through, stall counter running while ready is low
// ABORT  | single cycle: downstream valid masked, error answered upstream
module reg_timeout_guard #(
   parameter int unsigned TimeoutCycles = 256,
   parameter logic [31:0] ErrData       = 32'hBADC_AB1E,
   parameter int unsigned CntWidth      = 8,
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned DataWidth     = 32,
   parameter type         req_t         = reg_timeout_guard_pkg::req_t,
   parameter type         rsp_t         = reg_timeout_guard_pkg::rsp_t
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  req_t                 req_i,
   output rsp_t                 rsp_o,
   output req_t                 req_o,
   input  rsp_t                 rsp_i,
   output logic                 timeout_o,
   output logic [AddrWidth-1:0] timeout_addr_o,
   output logic [CntWidth-1:0]  timeout_cnt_o,
   input  logic                 timeout_cnt_clr_i,
   output logic                 busy_o
);

   localparam bit          Enabled  = (TimeoutCycles != 0);
   localparam int unsigned StallW   = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
   localparam logic [StallW-1:0]    StallMax = StallW'(TimeoutCycles - 1);
   localparam logic [DataWidth-1:0] ErrDataW = DataWidth'(ErrData);

   typedef enum logic {
      ACTIVE = 1'b0,
      ABORT  = 1'b1
   } state_e;

   state_e                state_q;
   logic [StallW-1:0]     stall_q;
   logic                  timeout_q;
   logic [AddrWidth-1:0]  addr_q;
   logic [CntWidth-1:0]   cnt_q;
   logic                  stalled;
   logic                  abort_go;

   assign stalled  = req_i.valid && !rsp_i.ready;
   assign abort_go = Enabled && stalled && (stall_q == StallMax);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ACTIVE;
         stall_q   <= '0;
         timeout_q <= 1'b0;
         addr_q    <= '0;
         cnt_q     <= '0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            ACTIVE: begin
               if (abort_go) begin
                  state_q   <= ABORT;
                  stall_q   <= '0;
                  timeout_q <= 1'b1;
               end else if (Enabled && stalled) begin
                  stall_q <= stall_q + 1'b1;
               end else begin
                  stall_q <= '0;
               end
            end
            ABORT: begin
               state_q <= ACTIVE;
               stall_q <= '0;
               addr_q  <= AddrWidth'(req_i.addr);
               if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            end
            default: begin
               state_q <= ACTIVE;
               stall_q <= '0;
            end
         endcase
         // a clear coinciding with an abort takes priority over the increment
         if (timeout_cnt_clr_i) cnt_q <= '0;
      end
   end

   always_comb begin
      req_o = req_i;
      rsp_o = rsp_i;
      if (state_q == ABORT) begin
         req_o.valid = 1'b0;
         rsp_o.ready = 1'b1;
         rsp_o.error = 1'b1;
         rsp_o.rdata = ErrDataW;
      end
   end

   assign busy_o         = req_i.valid && (state_q == ACTIVE);
   assign timeout_o      = timeout_q;
   assign timeout_addr_o = addr_q;
   assign timeout_cnt_o  = cnt_q;

endmodule
